// File: rtl/adder_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used as the bit-slice datapath.
module full_adder (
  input  logic a_in,
  input  logic b_in,
  input  logic c_in,
  output logic sum_out,
  output logic c_out
);

  assign sum_out = a_in ^ b_in ^ c_in;
  assign c_out   = (a_in & b_in) | (c_in & (a_in ^ b_in));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: steps one full adder LSB-first over WIDTH bits.
// States: IDLE waits for start | RUN one bit per clock | DONE one-cycle result pulse.
module serial_adder_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             c_out
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [WIDTH-1:0] sum_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_carry;
  logic             last_bit;

  full_adder u_fa (
    .a_in    (a_sr[0]),
    .b_in    (b_sr[0]),
    .c_in    (carry),
    .sum_out (fa_sum),
    .c_out   (fa_carry)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));
  // New sum bit enters at the MSB; written with shifts so WIDTH=1 needs no special case.
  assign sum_nxt  = (sum_sr >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_in) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      a_sr    <= '0;
      b_sr    <= '0;
      sum_sr  <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      sum_out <= '0;
      c_out   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_in) begin
            a_sr   <= a_in;
            b_sr   <= b_in;
            carry  <= c_in;
            cnt    <= '0;
            sum_sr <= '0;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          carry  <= fa_carry;
          sum_sr <= sum_nxt;
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            sum_out <= sum_nxt;
            c_out   <= fa_carry;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_out = (state == RUN);
  assign done_out = (state == DONE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized self-checking bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, c8, busy8, done8, co8;
  logic [7:0] a8, b8, sum8;
  logic       start1, c1, busy1, done1, co1;
  logic [0:0] a1, b1, sum1;

  int errors = 0;
  int checks = 0;
  int prev_sum [2];
  int prev_c   [2];

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk_in(clk), .rst_in(rst), .start_in(start8), .a_in(a8), .b_in(b8), .c_in(c8),
    .busy_out(busy8), .done_out(done8), .sum_out(sum8), .c_out(co8)
  );

  serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
    .clk_in(clk), .rst_in(rst), .start_in(start1), .a_in(a1), .b_in(b1), .c_in(c1),
    .busy_out(busy1), .done_out(done1), .sum_out(sum1), .c_out(co1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int idx(input int w);
    return (w == 1) ? 1 : 0;
  endfunction

  function automatic logic [31:0] o_sum(input int w);
    return (w == 1) ? 32'(sum1) : 32'(sum8);
  endfunction
  function automatic logic o_c(input int w);
    return (w == 1) ? co1 : co8;
  endfunction
  function automatic logic o_busy(input int w);
    return (w == 1) ? busy1 : busy8;
  endfunction
  function automatic logic o_done(input int w);
    return (w == 1) ? done1 : done8;
  endfunction

  task automatic drive(input int w, input logic s, input logic [7:0] a, input logic [7:0] b,
                       input logic c);
    if (w == 1) begin
      start1 = s; a1 = a[0]; b1 = b[0]; c1 = c;
    end else begin
      start8 = s; a8 = a; b8 = b; c8 = c;
    end
  endtask

  // Reference: plain unsigned addition of the operands truncated to w bits.
  task automatic model(input int w, input logic [7:0] a, input logic [7:0] b, input logic c,
                       output int s, output int co);
    int mask, full;
    mask = (1 << w) - 1;
    full = (int'(a) & mask) + (int'(b) & mask) + int'(c);
    s    = full & mask;
    co   = (full >> w) & 1;
  endtask

  task automatic op(input int w, input logic [7:0] a, input logic [7:0] b, input logic c,
                    input bit noise);
    int es, ec, busy_cnt, done_at;
    model(w, a, b, c, es, ec);
    busy_cnt = 0;
    done_at  = -1;
    @(negedge clk);
    drive(w, 1'b1, a, b, c);
    @(posedge clk);
    for (int k = 0; k <= w + 1; k++) begin
      @(negedge clk);
      if (o_busy(w)) busy_cnt++;
      if (o_done(w) && done_at < 0) done_at = k;
      if (k == w - 1) begin
        chk("hold_sum", o_sum(w), 32'(prev_sum[idx(w)]));
        chk("hold_c", 32'(o_c(w)), 32'(prev_c[idx(w)]));
      end
      if (k == w) begin
        chk("sum", o_sum(w), 32'(es));
        chk("carry", 32'(o_c(w)), 32'(ec));
      end
      if (k == w + 1) begin
        chk("done_width", 32'(o_done(w)), 32'd0);
        chk("busy_after", 32'(o_busy(w)), 32'd0);
      end
      if (noise && k <= w)
        drive(w, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom));
      else
        drive(w, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
    end
    @(negedge clk);
    chk("no_second_done", 32'(o_done(w)), 32'd0);
    chk("done_edge", 32'(done_at), 32'(w));
    chk("busy_cycles", 32'(busy_cnt), 32'(w));
    prev_sum[idx(w)] = es;
    prev_c[idx(w)]   = ec;
  endtask

  task automatic reset_test(input int w);
    int n;
    n = (w >= 4) ? 4 : w;
    @(negedge clk);
    drive(w, 1'b1, 8'hFF, 8'hFF, 1'b0);
    @(posedge clk);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      drive(w, 1'b0, 8'h00, 8'h00, 1'b0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(o_busy(w)), 32'd0);
    chk("rst_done", 32'(o_done(w)), 32'd0);
    chk("rst_sum", o_sum(w), 32'd0);
    chk("rst_c", 32'(o_c(w)), 32'd0);
    rst = 1'b0;
    prev_sum[0] = 0; prev_c[0] = 0;
    prev_sum[1] = 0; prev_c[1] = 0;
    for (int k = 0; k < w + 3; k++) begin
      @(negedge clk);
      chk("rst_no_done", 32'(o_done(w) | o_busy(w)), 32'd0);
    end
    op(w, 8'h01, 8'h01, 1'b0, 1'b0);
  endtask

  task automatic hold_test(input int w);
    logic [7:0] a, b;
    int es, ec, last, pulses;
    a = 8'($urandom);
    b = 8'($urandom);
    model(w, a, b, 1'b0, es, ec);
    last   = -1;
    pulses = 0;
    @(negedge clk);
    drive(w, 1'b1, a, b, 1'b0);
    for (int i = 0; i < 5 * (w + 2); i++) begin
      @(negedge clk);
      if (o_done(w)) begin
        if (last >= 0) chk("throughput", 32'(i - last), 32'(w + 2));
        chk("hold_run_sum", o_sum(w), 32'(es));
        last = i;
        pulses++;
      end
    end
    chk("hold_pulses", 32'(pulses >= 4), 32'd1);
    drive(w, 1'b0, a, b, 1'b0);
    repeat (w + 4) @(negedge clk);
    chk("hold_idle", 32'(o_busy(w) | o_done(w)), 32'd0);
    prev_sum[idx(w)] = es;
    prev_c[idx(w)]   = ec;
  endtask

  initial begin
    int widths [2];
    widths = '{8, 1};
    rst = 1'b1;
    drive(8, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
    prev_sum = '{0, 0};
    prev_c   = '{0, 0};
    repeat (2) @(negedge clk);
    foreach (widths[i]) begin
      chk("init_busy", 32'(o_busy(widths[i])), 32'd0);
      chk("init_done", 32'(o_done(widths[i])), 32'd0);
      chk("init_sum", o_sum(widths[i]), 32'd0);
      chk("init_c", 32'(o_c(widths[i])), 32'd0);
    end
    rst = 1'b0;

    foreach (widths[i]) begin
      op(widths[i], 8'h00, 8'h00, 1'b0, 1'b0);
      op(widths[i], 8'hFF, 8'h01, 1'b0, 1'b0);
      op(widths[i], 8'h3C, 8'h0F, 1'b0, 1'b0);
      op(widths[i], 8'hA5, 8'h5A, 1'b1, 1'b0);
      op(widths[i], 8'h12, 8'h34, 1'b0, 1'b1);
      reset_test(widths[i]);
      hold_test(widths[i]);
      op(widths[i], 8'h01, 8'h01, 1'b1, 1'b0);
      for (int r = 0; r < 15; r++)
        op(widths[i], 8'($urandom), 8'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
